// File: rtl/result_sel_stage.sv
// Result select stage: picks one of NCH channels (or a forced zero) and
// holds the selected results in a two-entry in-order skid buffer.
module result_sel_stage #(
  parameter int WIDTH    = 12,
  parameter int NCH      = 8,
  parameter int SELW     = 3,
  parameter int ZERO_SEL = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH*NCH-1:0]  in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  output logic                  out_zero,
  output logic                  out_badsel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  sel;
    logic             zero;
    logic             bad;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [SELW:0] NCH_L = (SELW + 1)'(NCH);

  logic [WIDTH-1:0] masked [NCH];
  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  entry_t           new_entry;
  entry_t           head_reg, head_next;
  entry_t           tail_reg, tail_next;
  state_t           state_reg, state_next;
  logic             push, pop;

  // Each channel contributes only when selected; the zero channel never does,
  // and an out-of-range selector matches no channel, so both yield zero.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam logic [SELW-1:0] IDX = SELW'(gi);
    if (gi == ZERO_SEL) begin : g_zero
      assign masked[gi] = '0;
    end else begin : g_data
      assign masked[gi] = (in_sel == IDX) ? in_data[gi*WIDTH +: WIDTH] : '0;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_data = sel_data | masked[k];
    end
  end

  assign sel_bad = ({1'b0, in_sel} >= NCH_L);

  always_comb begin
    new_entry.data = sel_data;
    new_entry.sel  = in_sel;
    new_entry.zero = (sel_data == '0);
    new_entry.bad  = sel_bad;
  end

  // Ready comes from the state register only, so no combinational path
  // from out_ready back to in_ready.
  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          head_next  = new_entry;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_next = new_entry;
        end else if (push) begin
          tail_next  = new_entry;
          state_next = TWO;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_next  = tail_reg;
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  assign out_data   = head_reg.data;
  assign out_sel    = head_reg.sel;
  assign out_zero   = head_reg.zero;
  assign out_badsel = head_reg.bad;

endmodule

// File: tb/tb_result_sel_stage.sv
// Scoreboard bench for result_sel_stage: three configurations, directed
// sequences on two of them and long random traffic on the third.
module tb_result_sel_stage;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  sel;
    logic        zero;
    logic        bad;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst   [3];
  logic [255:0] din   [3];
  logic [3:0]   sel   [3];
  logic         iv    [3];
  logic         irdy  [3];
  logic         ordy  [3];
  logic         ov    [3];
  logic         oz    [3];
  logic         ob    [3];
  logic [15:0]  od    [3];
  logic [3:0]   os    [3];

  logic [11:0]  a_od, c_od;
  logic [15:0]  b_od;
  logic [2:0]   a_os, c_os;
  logic [3:0]   b_os;

  int tpass = 0;
  int ttot  = 0;

  always #5 clk = ~clk;

  result_sel_stage #(.WIDTH(12), .NCH(8), .SELW(3), .ZERO_SEL(0)) dut_a (
    .clk(clk), .reset(rst[0]), .in_data(din[0][95:0]), .in_sel(sel[0][2:0]),
    .in_valid(iv[0]), .in_ready(irdy[0]), .out_data(a_od), .out_sel(a_os),
    .out_zero(oz[0]), .out_badsel(ob[0]), .out_valid(ov[0]), .out_ready(ordy[0]));

  result_sel_stage #(.WIDTH(16), .NCH(12), .SELW(4), .ZERO_SEL(3)) dut_b (
    .clk(clk), .reset(rst[1]), .in_data(din[1][191:0]), .in_sel(sel[1]),
    .in_valid(iv[1]), .in_ready(irdy[1]), .out_data(b_od), .out_sel(b_os),
    .out_zero(oz[1]), .out_badsel(ob[1]), .out_valid(ov[1]), .out_ready(ordy[1]));

  result_sel_stage #(.WIDTH(12), .NCH(6), .SELW(3), .ZERO_SEL(0)) dut_c (
    .clk(clk), .reset(rst[2]), .in_data(din[2][71:0]), .in_sel(sel[2][2:0]),
    .in_valid(iv[2]), .in_ready(irdy[2]), .out_data(c_od), .out_sel(c_os),
    .out_zero(oz[2]), .out_badsel(ob[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  assign od[0] = {4'b0, a_od};
  assign od[1] = b_od;
  assign od[2] = {4'b0, c_od};
  assign os[0] = {1'b0, a_os};
  assign os[1] = b_os;
  assign os[2] = {1'b0, c_os};

  // Reference: the selected channel, or zero for the zero index / bad index.
  function automatic exp_t model(input logic [255:0] d, input logic [3:0] s,
                                 input int w, input int n, input int zs);
    exp_t m;
    m      = '0;
    m.sel  = s;
    m.bad  = (int'(s) >= n);
    if (!m.bad && int'(s) != zs) begin
      for (int b = 0; b < w; b++) m.data[b] = d[int'(s) * w + b];
    end
    m.zero = (m.data == 16'h0);
    return m;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : sb
    localparam int W  = (gi == 1) ? 16 : 12;
    localparam int N  = (gi == 0) ? 8 : ((gi == 1) ? 12 : 6);
    localparam int ZS = (gi == 1) ? 3 : 0;
    exp_t q[$];
    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      ntot++;
      if (act === req) npass++;
      else $display("FAIL inst%0d %s: got %h, expected %h at %0t", gi, nm, act, req, $time);
    endtask

    // Stimulus side: every accepted offer enqueues its expected result.
    always @(posedge clk) begin
      if (rst[gi]) q.delete();
      else if (iv[gi] && irdy[gi]) q.push_back(model(din[gi], sel[gi], W, N, ZS));
    end

    // Monitor side: occupancy, head contents, and pop on handshake.
    always @(negedge clk) begin
      exp_t got;
      got = '{data: od[gi], sel: os[gi], zero: oz[gi], bad: ob[gi]};
      if (rst[gi]) begin
        chk("reset_outputs", {8'b0, ov[gi], irdy[gi], got}, {8'b0, 1'b0, 1'b1, 22'b0});
      end else begin
        chk("out_valid", {31'b0, ov[gi]}, {31'b0, q.size() != 0});
        chk("in_ready", {31'b0, irdy[gi]}, {31'b0, q.size() < 2});
        if (ov[gi] && q.size() > 0) begin
          chk("head_entry", {10'b0, got}, {10'b0, q[0]});
          if (ordy[gi]) void'(q.pop_front());
        end
      end
    end
  end

  task automatic tchk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ttot++;
    if (act === req) tpass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
  endtask

  task automatic drive(input int i, input logic [3:0] s, input logic [255:0] d);
    iv[i]  = 1'b1;
    sel[i] = s;
    din[i] = d;
  endtask

  // Holds the current offer until it is taken at a clock edge.
  task automatic wait_acc(input int i);
    logic hs;
    for (int n = 0; n < 50; n++) begin
      hs = irdy[i];
      @(posedge clk);
      #1;
      if (hs) begin
        iv[i] = 1'b0;
        return;
      end
    end
    tchk("accept_timeout", 32'd0, 32'd1);
    iv[i] = 1'b0;
  endtask

  task automatic offer(input int i, input logic [3:0] s, input logic [255:0] d);
    drive(i, s, d);
    wait_acc(i);
  endtask

  task automatic seq_a();
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*12 +: 12] = 12'h100 + 12'(k);
    ordy[0] = 1'b1;
    for (int k = 0; k < 8; k++) offer(0, 4'(k), d);
    repeat (3) @(posedge clk);
    #1;
    // Stall: two entries fill the buffer, third offer held until drain.
    ordy[0] = 1'b0;
    offer(0, 4'd2, d);
    offer(0, 4'd3, d);
    tchk("ready_after_two", {31'b0, irdy[0]}, 32'd0);
    drive(0, 4'd5, d);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tchk("held_data", {20'b0, od[0][11:0]}, 32'h102);
    ordy[0] = 1'b1;
    wait_acc(0);
    repeat (3) @(posedge clk);
    #1;
    // Simultaneous push and pop while holding one entry.
    ordy[0] = 1'b0;
    offer(0, 4'd1, d);
    ordy[0] = 1'b1;
    offer(0, 4'd4, d);
    tchk("pushpop_head", {20'b0, od[0][11:0]}, 32'h104);
    repeat (2) @(posedge clk);
    #1;
    // Fill to two, then reset between edges.
    ordy[0] = 1'b0;
    offer(0, 4'd6, d);
    offer(0, 4'd7, d);
    @(negedge clk);
    #2;
    rst[0] = 1'b1;
    #1;
    tchk("async_rst_valid", {31'b0, ov[0]}, 32'd0);
    tchk("async_rst_ready", {31'b0, irdy[0]}, 32'd1);
    tchk("async_rst_data", {20'b0, od[0][11:0]}, 32'd0);
    @(posedge clk);
    #1;
    rst[0]  = 1'b0;
    ordy[0] = 1'b1;
    offer(0, 4'd7, d);
  endtask

  task automatic seq_c();
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 6; k++) d[k*12 +: 12] = 12'($urandom) | 12'h001;
    d[3*12 +: 12] = 12'h000;
    ordy[2] = 1'b1;
    offer(2, 4'd6, d);
    offer(2, 4'd7, d);
    offer(2, 4'd2, d);
    offer(2, 4'd3, d);
    offer(2, 4'd0, d);
    offer(2, 4'd5, d);
  endtask

  task automatic seq_b();
    for (int c = 0; c < 10000; c++) begin
      iv[1]   = ($urandom_range(0, 3) != 0);
      ordy[1] = ($urandom_range(0, 3) != 0);
      sel[1]  = 4'($urandom_range(0, 15));
      for (int k = 0; k < 12; k++)
        din[1][k*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      @(posedge clk);
      #1;
    end
    iv[1] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; din[i] = '0; sel[i] = '0; iv[i] = 1'b0; ordy[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    fork
      begin
        seq_a();
        seq_c();
      end
      seq_b();
    join
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    repeat (6) @(posedge clk);
    #1;
    tchk("drain_a", 32'(sb[0].q.size()), 32'd0);
    tchk("drain_b", 32'(sb[1].q.size()), 32'd0);
    tchk("drain_c", 32'(sb[2].q.size()), 32'd0);
    $display("%0d/%0d checks passed",
             tpass + sb[0].npass + sb[1].npass + sb[2].npass,
             ttot + sb[0].ntot + sb[1].ntot + sb[2].ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/result_sel_stage.md
RESULT_SEL_STAGE -- requirements
Module: result_sel_stage

Interface
- REQ-001 SHALL provide parameter WIDTH, default 12, datapath width of every channel and of the result.
- REQ-002 SHALL provide parameter NCH, default 8, number of input channels (legal range 2..16).
- REQ-003 SHALL provide parameter SELW, default 3, selector width; ceil(log2(NCH)) <= SELW <= 4.
- REQ-004 SHALL provide parameter ZERO_SEL, default 0, channel index whose result is forced to all-zeros regardless of its data (hard-wired zero operation).
- REQ-005 SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
- REQ-006 SHALL provide port reset, input, 1, asynchronous active-high reset.
- REQ-007 SHALL provide port in_data, input, WIDTH*NCH, channel k occupies bits [k*WIDTH +: WIDTH].
- REQ-008 SHALL provide port in_sel, input, SELW, channel selector.
- REQ-009 SHALL provide port in_valid, input, 1, upstream offers in_data/in_sel.
- REQ-010 SHALL provide port in_ready, output, 1, stage accepts this cycle.
- REQ-011 SHALL provide port out_data, output, WIDTH, selected result at buffer head.
- REQ-012 SHALL provide port out_sel, output, SELW, selector that produced out_data.
- REQ-013 SHALL provide port out_zero, output, 1, out_data is all-zeros.
- REQ-014 SHALL provide port out_badsel, output, 1, head entry had in_sel >= NCH.
- REQ-015 SHALL provide port out_valid, output, 1, head entry valid.
- REQ-016 SHALL provide port out_ready, input, 1, downstream accepts head.

Function
- REQ-017 Selection SHALL be: in_sel == ZERO_SEL -> 0; in_sel >= NCH -> 0 with badsel=1; otherwise channel in_sel.
- REQ-018 zero flag SHALL be computed on the selected value (true for ZERO_SEL, badsel, or a genuinely zero channel).
- REQ-019 Push SHALL occur when in_valid && in_ready; pop when out_valid && out_ready.
- REQ-020 Stage SHALL hold a 2-entry in-order buffer with state EMPTY, ONE, TWO.
- REQ-021 in_ready SHALL equal (state != TWO) and depend on registers only, never on out_ready.
- REQ-022 out_valid SHALL equal (state != EMPTY); outputs SHALL be driven from the head entry only.
- REQ-023 EMPTY: push -> ONE; no push -> EMPTY; push-to-out_valid latency exactly 1 cycle.
- REQ-024 ONE: push&pop -> ONE, new entry becomes head next cycle; push only -> TWO; pop only -> EMPTY.
- REQ-025 TWO: pop -> ONE, second entry becomes head; no pop -> TWO; no push possible.
- REQ-026 Head outputs SHALL remain stable while out_valid && !out_ready.
- REQ-027 Entries SHALL never be dropped, duplicated or reordered; sustained throughput 1 transfer/cycle when out_ready held high.
- REQ-028 in_data/in_sel SHALL be ignored when no push occurs, including X values.

Reset
- REQ-029 reset high SHALL immediately (asynchronously) set state EMPTY, out_valid 0, out_data 0, out_sel 0, out_zero 0, out_badsel 0, in_ready 1.
- REQ-030 reset asserted mid-operation SHALL discard all buffered entries; a push in the reset-release cycle is accepted normally.

Verification
- REQ-031 Defaults, out_ready=1, in_sel=0..7 with channel k = 12'h100+k, one per cycle -> out_data 0 (zero=1) for sel 0, 12'h101..12'h107 for 1..7, one cycle later each, no bubbles.
- REQ-032 NCH=6, SELW=3, in_sel=6 and 7 -> out_data 0, out_badsel=1, out_zero=1.
- REQ-033 out_ready=0, push A,B -> in_ready falls after second push; third offer C held; out_ready=1 -> A, B, C delivered in order, A stable throughout stall.
- REQ-034 State ONE, simultaneous push C and pop A -> state stays ONE, next-cycle head = C.
- REQ-035 State TWO, assert reset between clock edges -> out_valid 0 and in_ready 1 before next edge; no stale entry emerges after release.
- REQ-036 Random valid/ready over 10k cycles, WIDTH=16, NCH=12, SELW=4 -> scoreboard matches, every in_valid&&in_ready transfer appears exactly once.
